rom_read_sequencer: RTL and testbench

- Drives the parallel ROM chip bus: address, active-low chip enable (CE#) and output enable (OE#). Sweeps an address range and samples each data word after a programmable access time.
- Sits downstream of the debounced "read" button. A single `start` pulse launches one full dump.
- Each sampled word goes to the transfer path (e.g. UART TX) over a valid/ready handshake. The sequencer stalls until each word is accepted.

---
 rtl/rom_read_sequencer.sv | 135 +++++++++++++
 tb/tb_rom_read_sequencer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_sequencer.sv
// Parallel ROM dump sequencer: sweeps addresses 0..end_addr and hands each word off over valid/ready.
// Optional ROM_READ_CHECKSUM_EN adds a 16-bit running sum of accepted words on `checksum`.
module rom_read_sequencer #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int ACCESS_CYCLES   = 10,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce_n,
    output logic                  rom_oe_n,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  done
`ifdef ROM_READ_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    localparam int CNT_MAX = (ACCESS_CYCLES > RECOVERY_CYCLES) ? ACCESS_CYCLES : RECOVERY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HANDOFF,
        RECOVER,
        DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] end_latched;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            end_latched <= '0;
            rom_addr    <= '0;
            rom_ce_n    <= 1'b1;
            rom_oe_n    <= 1'b1;
            data_out    <= '0;
            data_addr   <= '0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef ROM_READ_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        end_latched <= end_addr;
                        rom_addr    <= '0;
                        busy        <= 1'b1;
                        rom_ce_n    <= 1'b0;
                        cnt         <= '0;
                        state       <= SETUP;
`ifdef ROM_READ_CHECKSUM_EN
                        checksum    <= '0;
`endif
                    end
                end
                SETUP: begin
                    rom_oe_n <= 1'b0;
                    cnt      <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // Sample on the edge that closes the final access cycle, releasing the bus at once
                    if (cnt == ACC_LAST) begin
                        data_out   <= rom_data;
                        data_addr  <= rom_addr;
                        data_valid <= 1'b1;
                        rom_ce_n   <= 1'b1;
                        rom_oe_n   <= 1'b1;
                        cnt        <= '0;
                        state      <= HANDOFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HANDOFF: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= RECOVER;
`ifdef ROM_READ_CHECKSUM_EN
                        checksum   <= checksum + 16'(data_out);
`endif
                    end
                end
                RECOVER: begin
                    if (cnt == REC_LAST) begin
                        cnt <= '0;
                        // Compare before incrementing so end_addr=all-ones never wraps
                        if (rom_addr == end_latched) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            rom_ce_n <= 1'b0;
                            state    <= SETUP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Scoreboard bench for rom_read_sequencer: a 16-bit/10-cycle instance and a 4-bit full-range instance.
module tb_rom_read_sequencer;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start = 1'b0;
    logic [15:0] end_addr = '0;
    logic [15:0] rom_addr;
    logic        rom_ce_n, rom_oe_n;
    logic [7:0]  rom_data;
    logic [7:0]  data_out;
    logic [15:0] data_addr;
    logic        data_valid;
    logic        data_ready = 1'b1;
    logic        busy, done;

    logic        start_b = 1'b0;
    logic [3:0]  end_addr_b = '0;
    logic [3:0]  rom_addr_b;
    logic        rom_ce_n_b, rom_oe_n_b;
    logic [7:0]  rom_data_b;
    logic [7:0]  data_out_b;
    logic [3:0]  data_addr_b;
    logic        data_valid_b;
    logic        data_ready_b = 1'b1;
    logic        busy_b, done_b;

`ifdef ROM_READ_CHECKSUM_EN
    logic [15:0] checksum, checksum_b;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    assign rom_data   = rom_addr[7:0] ^ 8'hA5;
    assign rom_data_b = {4'h0, rom_addr_b};

    always #5 clk = ~clk;

    rom_read_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .ACCESS_CYCLES(10), .RECOVERY_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .end_addr(end_addr),
        .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_data(rom_data),
        .data_out(data_out), .data_addr(data_addr), .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy), .done(done)
`ifdef ROM_READ_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    rom_read_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ACCESS_CYCLES(3), .RECOVERY_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .end_addr(end_addr_b),
        .rom_addr(rom_addr_b), .rom_ce_n(rom_ce_n_b), .rom_oe_n(rom_oe_n_b), .rom_data(rom_data_b),
        .data_out(data_out_b), .data_addr(data_addr_b), .data_valid(data_valid_b), .data_ready(data_ready_b),
        .busy(busy_b), .done(done_b)
`ifdef ROM_READ_CHECKSUM_EN
        , .checksum(checksum_b)
`endif
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rom_ce_n !== 1'b1 || rom_oe_n !== 1'b1 || rom_addr !== 16'h0 || data_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || data_out !== 8'h0 || data_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: ce_n=%b oe_n=%b addr=%h valid=%b busy=%b done=%b dout=%h daddr=%h, need 1 1 0 0 0 0 0 0",
                     rom_ce_n, rom_oe_n, rom_addr, data_valid, busy, done, data_out, data_addr);
        end
        checks++;
        if (rom_ce_n_b !== 1'b1 || rom_oe_n_b !== 1'b1 || busy_b !== 1'b0 || data_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_b: ce_n=%b oe_n=%b busy=%b valid=%b, need 1 1 0 0",
                     rom_ce_n_b, rom_oe_n_b, busy_b, data_valid_b);
        end
`ifdef ROM_READ_CHECKSUM_EN
        checks++;
        if (checksum !== 16'h0) begin
            errors++;
            $display("FAIL reset_checksum: got %h need 0000", checksum);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int c, first_lat, done_seen;
        logic [15:0] sum;
        exp_t e;
        sb.delete();
        sum = '0;
        end_addr = 16'd3;
        data_ready = 1'b1;
        for (int a = 0; a <= 3; a++) begin
            e.addr = 16'(a);
            e.data = 8'(a) ^ 8'hA5;
            sb.push_back(e);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rom_addr !== 16'h0) begin
            errors++;
            $display("FAIL start_busy: busy=%b addr=%h need 1 0000", busy, rom_addr);
        end
        c = 0; first_lat = -1; done_seen = 0;
        while (c < 400) begin
            @(posedge clk); #1;
            c++;
            checks++;
            if (!rom_oe_n && rom_ce_n) begin
                errors++;
                $display("FAIL oe_without_ce: oe_n=%b ce_n=%b", rom_oe_n, rom_ce_n);
            end
            if (data_valid && first_lat < 0) begin
                first_lat = c;
                checks++;
                if (c != 11) begin
                    errors++;
                    $display("FAIL first_latency: got %0d cycles need 11", c);
                end
            end
            if (data_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got addr %h data %h, none expected", data_addr, data_out);
                end else begin
                    e = sb.pop_front();
                    sum = sum + 16'(data_out);
                    if (data_out !== e.data || data_addr !== e.addr) begin
                        errors++;
                        $display("FAIL basic_word: got %h@%h need %h@%h", data_out, data_addr, e.data, e.addr);
                    end
                end
            end
            if (done) begin
                done_seen++;
`ifdef ROM_READ_CHECKSUM_EN
                checks++;
                if (checksum !== sum) begin
                    errors++;
                    $display("FAIL basic_checksum: got %h need %h", checksum, sum);
                end
`endif
            end
            if (done_seen > 0 && !done) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_after_done: got %b need 0", busy);
                end
                break;
            end
        end
        checks++;
        if (done_seen != 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d need 1", done_seen);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL basic_missing: %0d words not seen, need 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        int c, stall, bad;
        logic [7:0]  snap_d;
        logic [15:0] snap_a;
        exp_t e;
        sb.delete();
        end_addr = 16'd2;
        data_ready = 1'b0;
        for (int a = 0; a <= 2; a++) begin
            e.addr = 16'(a);
            e.data = 8'(a) ^ 8'hA5;
            sb.push_back(e);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0; stall = 0; bad = 0; snap_d = '0; snap_a = '0;
        while (c < 600 && !done) begin
            @(posedge clk); #1;
            c++;
            if (data_valid) begin
                if (data_addr == 16'd1 && stall < 20) begin
                    if (stall == 0) begin
                        snap_d = data_out;
                        snap_a = data_addr;
                    end else begin
                        checks++;
                        if (data_out !== snap_d || data_addr !== snap_a || !rom_ce_n || !rom_oe_n || rom_addr !== 16'd1) begin
                            errors++;
                            bad++;
                            $display("FAIL stall_stable: dout=%h daddr=%h ce_n=%b oe_n=%b addr=%h need %h %h 1 1 0001",
                                     data_out, data_addr, rom_ce_n, rom_oe_n, rom_addr, snap_d, snap_a);
                        end
                    end
                    stall++;
                    data_ready = 1'b0;
                end else begin
                    data_ready = 1'b1;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL bp_extra_word: got %h@%h", data_out, data_addr);
                    end else begin
                        e = sb.pop_front();
                        if (data_out !== e.data || data_addr !== e.addr) begin
                            errors++;
                            $display("FAIL bp_word: got %h@%h need %h@%h", data_out, data_addr, e.data, e.addr);
                        end
                    end
                end
            end else begin
                data_ready = 1'b0;
            end
        end
        checks++;
        if (stall != 20 || sb.size() != 0 || !done) begin
            errors++;
            $display("FAIL bp_summary: stall=%0d left=%0d done=%b need 20 0 1", stall, sb.size(), done);
        end
        data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_single_ignored();
        int c, words, stray;
        exp_t e;
        sb.delete();
        end_addr = 16'd0;
        data_ready = 1'b1;
        e.addr = 16'h0; e.data = 8'hA5;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0; words = 0;
        while (c < 300) begin
            @(posedge clk); #1;
            c++;
            start = 1'b0;
            if (c == 3) begin
                start = 1'b1;
                end_addr = 16'd5;
            end
            if (data_valid) begin
                words++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL single_extra_word: got %h@%h", data_out, data_addr);
                end else begin
                    e = sb.pop_front();
                    if (data_out !== e.data || data_addr !== e.addr) begin
                        errors++;
                        $display("FAIL single_word: got %h@%h need %h@%h", data_out, data_addr, e.data, e.addr);
                    end
                end
            end
            if (done) start = 1'b1;
            else if (words > 0 && !busy) break;
        end
        start = 1'b0;
        checks++;
        if (words != 1) begin
            errors++;
            $display("FAIL single_word_count: got %0d need 1", words);
        end
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || data_valid) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL ignored_start: %0d busy/valid cycles after done, need 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        bit hit;
        exp_t e;
        end_addr = 16'd3;
        data_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0; hit = 0;
        while (c < 300) begin
            @(posedge clk); #1;
            c++;
            if (rom_addr == 16'd2 && !rom_oe_n) begin
                hit = 1;
                break;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!hit || rom_ce_n !== 1'b1 || rom_oe_n !== 1'b1 || data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: reached=%b ce_n=%b oe_n=%b valid=%b busy=%b need 1 1 1 0 0",
                     hit, rom_ce_n, rom_oe_n, data_valid, busy);
        end
        reset = 1'b0;
        sb.delete();
        end_addr = 16'd1;
        for (int a = 0; a <= 1; a++) begin
            e.addr = 16'(a);
            e.data = 8'(a) ^ 8'hA5;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (c < 300 && !done) begin
            @(posedge clk); #1;
            c++;
            if (data_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL reread_extra_word: got %h@%h", data_out, data_addr);
                end else begin
                    e = sb.pop_front();
                    if (data_out !== e.data || data_addr !== e.addr) begin
                        errors++;
                        $display("FAIL reread_word: got %h@%h need %h@%h", data_out, data_addr, e.data, e.addr);
                    end
                end
            end
        end
        checks++;
        if (!done || sb.size() != 0) begin
            errors++;
            $display("FAIL reread_done: done=%b left=%0d need 1 0", done, sb.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_full_range();
        int c, words, wraps;
        logic [3:0]  prev;
        logic [15:0] sum;
        exp_t e;
        sb.delete();
        sum = '0;
        for (int a = 0; a < 16; a++) begin
            e.addr = 16'(a);
            e.data = 8'(a);
            sb.push_back(e);
            sum = sum + 16'(a);
        end
        end_addr_b = 4'hF;
        data_ready_b = 1'b1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        c = 0; words = 0; wraps = 0; prev = 4'h0;
        while (c < 2000 && !done_b) begin
            @(posedge clk); #1;
            c++;
            if (rom_addr_b < prev || (!rom_oe_n_b && rom_ce_n_b)) wraps++;
            prev = rom_addr_b;
            if (data_valid_b) begin
                words++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL full_extra_word: got %h@%h", data_out_b, data_addr_b);
                end else begin
                    e = sb.pop_front();
                    if (data_out_b !== e.data || {12'h0, data_addr_b} !== e.addr) begin
                        errors++;
                        $display("FAIL full_word: got %h@%h need %h@%h", data_out_b, data_addr_b, e.data, e.addr);
                    end
                end
            end
        end
        checks++;
        if (!done_b || words != 16 || rom_addr_b !== 4'hF || wraps != 0) begin
            errors++;
            $display("FAIL full_range: done=%b words=%0d addr=%h wraps=%0d need 1 16 f 0",
                     done_b, words, rom_addr_b, wraps);
        end
`ifdef ROM_READ_CHECKSUM_EN
        checks++;
        if (checksum_b !== 16'd120 || sum !== 16'd120) begin
            errors++;
            $display("FAIL full_checksum: got %0d need 120", checksum_b);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (busy_b !== 1'b0 || rom_addr_b !== 4'hF) begin
            errors++;
            $display("FAIL full_idle: busy=%b addr=%h need 0 f", busy_b, rom_addr_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_single_ignored();
        test_reset_mid();
        test_full_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
